mem_seq: RTL and testbench

- Memory sequencer between the LC-3 datapath (MAR/MDR side) and the off-chip asynchronous 16-bit SRAM.
- Accepts one read or write request at a time over a valid/ready handshake.
- Generates active-low CE/UB/LB/OE/WE with programmable wait states and owns the bidirectional Data bus.
- Maps one I/O address to the board switches (read) and a hex-display register (write) without touching the SRAM.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_seq_if.sv | 22 ++
 rtl/tristate_buffer.sv | 10 +
 rtl/mem_seq.sv | 157 +++++++++++++++
 tb/tb_mem_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 SRAM memory sequencer.
// Widths, the state encoding and the default I/O port address live here.
package mem_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [ADDR_W-1:0] IO_ADDR_DEFAULT = 20'h0FFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        HOLD    = 3'd3,
        RESP    = 3'd4,
        IO_RESP = 3'd5
    } state_e;

    function automatic logic is_io(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] io_addr);
        return (addr == io_addr);
    endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Request/response handshake between the datapath (master) and mem_seq (slave).
interface mem_seq_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/tristate_buffer.sv
// Drives a shared bus with i_data while i_en is high, otherwise releases it.
module tristate_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    inout  wire  [WIDTH-1:0] io_bus
);
    assign io_bus = i_en ? i_data : {WIDTH{1'bz}};
endmodule

// File: rtl/mem_seq.sv
// Memory sequencer: one request at a time to an asynchronous 16-bit SRAM with
// programmable wait states, plus a switch/hex I/O port that bypasses the SRAM.
module mem_seq
    import mem_pkg::*;
#(
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_seq_if.slave          bus,
    input  logic [DATA_W-1:0] S,
    output logic [DATA_W-1:0] hex_out,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam logic [CNT_W-1:0] LP_WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_seq: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_hex;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ce_n;
    logic              r_bytes_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_data_en;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              w_is_io;

    assign w_is_io = is_io(bus.req_addr, IO_ADDR);

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign hex_out       = r_hex;
    assign CE            = r_ce_n;
    assign UB            = r_bytes_n;
    assign LB            = r_bytes_n;
    assign OE            = r_oe_n;
    assign WE            = r_we_n;
    assign ADDR          = r_addr;

    tristate_buffer #(.WIDTH(DATA_W)) u_data_drv (
        .i_en   (r_data_en),
        .i_data (r_wdata),
        .io_bus (Data)
    );

    // Sequencer FSM: every SRAM pin is registered so it changes only on state edges.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_wdata     <= 16'h0000;
            r_rdata     <= 16'h0000;
            r_hex       <= 16'h0000;
            r_addr      <= 20'h00000;
            r_ce_n      <= 1'b1;
            r_bytes_n   <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_data_en   <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_is_write  <= bus.req_we;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (w_is_io) begin
                            if (bus.req_we) begin
                                r_hex <= bus.req_wdata;
                            end else begin
                                r_rdata <= S;
                            end
                            r_rsp_valid <= 1'b1;
                            r_state     <= IO_RESP;
                        end else begin
                            // OE only for reads; the data driver only for writes.
                            r_addr    <= bus.req_addr;
                            r_ce_n    <= 1'b0;
                            r_bytes_n <= 1'b0;
                            r_oe_n    <= bus.req_we;
                            r_data_en <= bus.req_we;
                            r_state   <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_cnt   <= LP_WAIT_LOAD;
                    r_we_n  <= ~r_is_write;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (r_is_write) begin
                            r_we_n  <= 1'b1;
                            r_state <= HOLD;
                        end else begin
                            r_rdata     <= Data;
                            r_ce_n      <= 1'b1;
                            r_bytes_n   <= 1'b1;
                            r_oe_n      <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    r_ce_n      <= 1'b1;
                    r_bytes_n   <= 1'b1;
                    r_data_en   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP, IO_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_ce_n      <= 1'b1;
                    r_bytes_n   <= 1'b1;
                    r_oe_n      <= 1'b1;
                    r_we_n      <= 1'b1;
                    r_data_en   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: a W=2 and a W=1 instance, each with a small SRAM model.
module tb_mem_seq;

    typedef struct {
        logic [15:0] data;
        int          edge_n;
    } exp_t;

    typedef struct packed {
        logic [5:0]  pins;
        logic        rdy;
        logic [15:0] d;
    } tr_t;

    logic        Clk;
    logic        Reset;
    logic [15:0] s_sw;
    int          ecnt = 0;
    int          checks = 0;
    int          errors = 0;

    exp_t q2[$];
    exp_t q1[$];
    tr_t  tr2 [0:1023];
    tr_t  tr1 [0:1023];

    mem_seq_if b2();
    mem_seq_if b1();

    logic [15:0] hex2, hex1;
    logic        ce2, ub2, lb2, oe2, we2;
    logic        ce1, ub1, lb1, oe1, we1;
    logic [19:0] addr2, addr1;
    wire  [15:0] data2, data1;
    logic [15:0] mem2 [0:255];
    logic [15:0] mem1 [0:255];

    mem_seq #(.WAIT_CYCLES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .bus(b2), .S(s_sw), .hex_out(hex2),
        .CE(ce2), .UB(ub2), .LB(lb2), .OE(oe2), .WE(we2), .ADDR(addr2), .Data(data2)
    );

    mem_seq #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .bus(b1), .S(s_sw), .hex_out(hex1),
        .CE(ce1), .UB(ub1), .LB(lb1), .OE(oe1), .WE(we1), .ADDR(addr1), .Data(data1)
    );

    assign data2 = (!ce2 && !oe2) ? mem2[addr2[7:0]] : 16'hzzzz;
    assign data1 = (!ce1 && !oe1) ? mem1[addr1[7:0]] : 16'hzzzz;

    always @(posedge we2) if (!ce2) mem2[addr2[7:0]] <= data2;
    always @(posedge we1) if (!ce1) mem1[addr1[7:0]] <= data1;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", nm, act, req, ecnt);
        end
    endtask

    function automatic logic [5:0] pins(input logic ce, input logic oe, input logic we, input logic en);
        return {ce, ce, ce, oe, we, en};
    endfunction

    // Pin trace indexed by edge count, plus the OE/WE exclusion invariant.
    always @(negedge Clk) begin
        tr2[ecnt[9:0]] <= '{{ce2, ub2, lb2, oe2, we2, dut2.r_data_en}, b2.req_ready, data2};
        tr1[ecnt[9:0]] <= '{{ce1, ub1, lb1, oe1, we1, dut1.r_data_en}, b1.req_ready, data1};
        chk("oe_we_excl_w2", {31'd0, (!oe2 && !we2)}, 32'd0);
        chk("oe_we_excl_w1", {31'd0, (!oe1 && !we1)}, 32'd0);
    end

    // Response monitors: pop one expectation per rsp_valid pulse.
    always @(negedge Clk) begin
        exp_t e;
        if (b2.rsp_valid) begin
            if (q2.size() == 0) begin
                chk("rsp2_unexpected", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("rsp2_rdata", {16'd0, b2.rsp_rdata}, {16'd0, e.data});
                chk("rsp2_edge", ecnt, e.edge_n);
            end
        end
        if (b1.rsp_valid) begin
            if (q1.size() == 0) begin
                chk("rsp1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("rsp1_rdata", {16'd0, b1.rsp_rdata}, {16'd0, e.data});
                chk("rsp1_edge", ecnt, e.edge_n);
            end
        end
    end

    task automatic rq2(input logic we, input logic [19:0] a, input logic [15:0] d, input logic [15:0] rexp,
                       input int lat, input bit want_rsp, input bit hold, output int acc);
        int g = 0;
        b2.req_valid = 1'b1; b2.req_we = we; b2.req_addr = a; b2.req_wdata = d;
        while (!b2.req_ready && g < 64) begin @(negedge Clk); g++; end
        if (g >= 64) chk("rq2_ready_timeout", 32'd0, 32'd1);
        acc = ecnt + 1;
        if (want_rsp) q2.push_back('{rexp, acc + lat});
        @(posedge Clk);
        @(negedge Clk);
        if (!hold) b2.req_valid = 1'b0;
    endtask

    task automatic rq1(input logic we, input logic [19:0] a, input logic [15:0] d, input logic [15:0] rexp,
                       input int lat, output int acc);
        int g = 0;
        b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d;
        while (!b1.req_ready && g < 64) begin @(negedge Clk); g++; end
        if (g >= 64) chk("rq1_ready_timeout", 32'd0, 32'd1);
        acc = ecnt + 1;
        q1.push_back('{rexp, acc + lat});
        @(posedge Clk);
        @(negedge Clk);
        b1.req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int k, k_rd, k_wr, k_io, k_b1, k_b2, k1w, k1r, k_rs;
        Reset = 1'b0;
        s_sw  = 16'h0000;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_addr = 20'h0; b2.req_wdata = 16'h0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 20'h0; b1.req_wdata = 16'h0;
        repeat (3) @(negedge Clk);
        chk("rst_pins_in_reset", {26'd0, ce2, ub2, lb2, oe2, we2, dut2.r_data_en}, {26'd0, 6'b111110});
        chk("rst_addr", {12'd0, addr2}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_ready", {31'd0, b2.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, b2.rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, b2.rsp_rdata}, 32'd0);
        chk("rst_hex", {16'd0, hex2}, 32'd0);

        // W=2 SRAM traffic
        rq2(1'b1, 20'h00010, 16'h1234, 16'h0000, 4, 1'b1, 1'b0, k);
        rq2(1'b0, 20'h00010, 16'h0000, 16'h1234, 3, 1'b1, 1'b0, k_rd);
        rq2(1'b1, 20'h00020, 16'hBEEF, 16'h1234, 4, 1'b1, 1'b0, k_wr);
        rq2(1'b0, 20'h00020, 16'h0000, 16'hBEEF, 3, 1'b1, 1'b0, k);

        // I/O port
        s_sw = 16'hA5A5;
        rq2(1'b0, 20'h0FFFF, 16'h0000, 16'hA5A5, 0, 1'b1, 1'b0, k_io);
        rq2(1'b1, 20'h0FFFF, 16'h00C3, 16'hA5A5, 0, 1'b1, 1'b0, k);
        chk("io_hex", {16'd0, hex2}, {16'd0, 16'h00C3});
        chk("io_addr_untouched", {12'd0, addr2}, {12'd0, 20'h00020});

        // Back-to-back reads with req_valid held
        rq2(1'b0, 20'h00010, 16'h0000, 16'h1234, 3, 1'b1, 1'b1, k_b1);
        rq2(1'b0, 20'h00020, 16'h0000, 16'hBEEF, 3, 1'b1, 1'b0, k_b2);
        chk("b2b_spacing", k_b2 - k_b1, 32'd5);

        // W=1 instance
        rq1(1'b1, 20'h00030, 16'h7777, 16'h0000, 3, k1w);
        rq1(1'b0, 20'h00030, 16'h0000, 16'h7777, 2, k1r);

        repeat (8) @(negedge Clk);
        chk("q2_drained", q2.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        for (int i = 0; i < 5; i++) begin
            chk("rd_pins", {26'd0, tr2[(k_rd + i) % 1024].pins}, {26'd0, pins(i > 2, i > 2, 1'b1, 1'b0)});
            chk("rd_ready", {31'd0, tr2[(k_rd + i) % 1024].rdy}, {31'd0, (i > 3)});
        end
        for (int i = 0; i < 6; i++) begin
            chk("wr_pins", {26'd0, tr2[(k_wr + i) % 1024].pins},
                {26'd0, pins(i > 3, 1'b1, !(i == 1 || i == 2), i <= 3)});
            if (i <= 3) chk("wr_data", {16'd0, tr2[(k_wr + i) % 1024].d}, {16'd0, 16'hBEEF});
        end
        for (int i = 0; i < 2; i++) begin
            chk("io_pins", {26'd0, tr2[(k_io + i) % 1024].pins}, {26'd0, 6'b111110});
        end
        for (int i = 0; i < 4; i++) begin
            chk("b2b_ready_low", {31'd0, tr2[(k_b1 + i) % 1024].rdy}, 32'd0);
        end
        chk("b2b_ce_gap_a", {31'd0, tr2[(k_b1 + 3) % 1024].pins[5]}, 32'd1);
        chk("b2b_ce_gap_b", {31'd0, tr2[(k_b1 + 4) % 1024].pins[5]}, 32'd1);
        chk("b2b_ce_second", {31'd0, tr2[k_b2 % 1024].pins[5]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("w1_wr_pins", {26'd0, tr1[(k1w + i) % 1024].pins},
                {26'd0, pins(i > 2, 1'b1, !(i == 1), i <= 2)});
        end
        for (int i = 0; i < 4; i++) begin
            chk("w1_rd_pins", {26'd0, tr1[(k1r + i) % 1024].pins}, {26'd0, pins(i > 1, i > 1, 1'b1, 1'b0)});
        end

        // Reset during write ACCESS: pins release without a clock edge, no response.
        rq2(1'b1, 20'h00040, 16'h1111, 16'h0000, 0, 1'b0, 1'b0, k_rs);
        @(negedge Clk);
        chk("rst_mid_pre_we", {31'd0, we2}, 32'd0);
        #2 Reset = 1'b0;
        #1;
        chk("rst_mid_pins", {26'd0, ce2, ub2, lb2, oe2, we2, dut2.r_data_en}, {26'd0, 6'b111110});
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_post_ready", {31'd0, b2.req_ready}, 32'd1);
        chk("rst_post_hex", {16'd0, hex2}, 32'd0);
        chk("rst_post_rdata", {16'd0, b2.rsp_rdata}, 32'd0);
        repeat (8) @(negedge Clk);
        chk("q2_final_empty", q2.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
